// File: rtl/tmr_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tmr_recovery_ctrl
// Purpose  : Recovery sequencer for a triple-redundant core cluster.
//            It enables the bus voter's checker and watches its mismatch flag.
//            On a single-hart divergence it halts every hart through debug
//            request, starts the state-resync routine, then releases the harts.
//            A multi-hart divergence is declared an uncorrectable fault.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i             in   1       clock
//   rst_ni            in   1       asynchronous active-low reset
//   tmr_enable_i      in   1       TMR mode enable (config register)
//   voter_error_i     in   1       voter mismatch flag
//   voter_error_id_i  in   NHARTS  per-hart mismatch vector from the voter
//   core_halted_i     in   NHARTS  per-hart debug-halted status
//   resync_done_i     in   1       resync routine finished (level or pulse)
//   voter_enable_o    out  1       voter checker enable
//   debug_req_o       out  NHARTS  halt request to every hart
//   resync_start_o    out  1       one-cycle pulse starting the state resync
//   faulty_hart_o     out  NHARTS  one-hot ID of the last corrected hart
//   fault_count_o     out  CNT_W   corrected-fault count, saturating
//   recovery_busy_o   out  1       recovery sequence in progress
//   fatal_o           out  1       uncorrectable fault or recovery timeout
// ============================================================================
module tmr_recovery_ctrl #(
  parameter int NHARTS  = 3,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tmr_enable_i,
  input  logic              voter_error_i,
  input  logic [NHARTS-1:0] voter_error_id_i,
  input  logic [NHARTS-1:0] core_halted_i,
  input  logic              resync_done_i,
  output logic              voter_enable_o,
  output logic [NHARTS-1:0] debug_req_o,
  output logic              resync_start_o,
  output logic [NHARTS-1:0] faulty_hart_o,
  output logic [CNT_W-1:0]  fault_count_o,
  output logic              recovery_busy_o,
  output logic              fatal_o
);

  // Timeout counter only has to reach TIMEOUT-1.
  localparam int              c_TMO_W    = $clog2(TIMEOUT);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

  localparam logic [2:0] c_ST_DISABLED = 3'd0;
  localparam logic [2:0] c_ST_ACTIVE   = 3'd1;
  localparam logic [2:0] c_ST_HALT     = 3'd2;
  localparam logic [2:0] c_ST_RESYNC   = 3'd3;
  localparam logic [2:0] c_ST_RELEASE  = 3'd4;
  localparam logic [2:0] c_ST_FATAL    = 3'd5;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               r_drop_pending;
  logic               r_resync_pulse;
  logic [NHARTS-1:0]  r_faulty_hart;
  logic [CNT_W-1:0]   r_fault_cnt;

  logic [NHARTS-1:0]  w_id_low_cleared;
  logic               w_err_single;
  logic               w_err_multi;
  logic               w_all_halted;
  logic               w_none_halted;
  logic               w_tmo_hit;
  logic               w_capture_fault;

  // id & (id-1) clears the lowest set bit: zero result with a non-zero id
  // means exactly one hart diverged, non-zero result means two or more.
  // An all-zero id with the error flag set carries no culprit and is ignored.
  assign w_id_low_cleared = voter_error_id_i & (voter_error_id_i - NHARTS'(1));
  assign w_err_single     = voter_error_i && (voter_error_id_i != '0) &&
                            (w_id_low_cleared == '0);
  assign w_err_multi      = voter_error_i && (w_id_low_cleared != '0);

  assign w_all_halted     = &core_halted_i;
  assign w_none_halted    = ~|core_halted_i;
  assign w_tmo_hit        = (r_tmo_cnt == c_TMO_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_ST_DISABLED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_DISABLED: begin
        if (tmr_enable_i) w_state_next = c_ST_ACTIVE;
      end
      c_ST_ACTIVE: begin
        // Disabling wins over an error seen in the same cycle.
        if (!tmr_enable_i)     w_state_next = c_ST_DISABLED;
        else if (w_err_single) w_state_next = c_ST_HALT;
        else if (w_err_multi)  w_state_next = c_ST_FATAL;
      end
      c_ST_HALT: begin
        // A disable aborts the recovery: skip resync and let the harts go.
        // A full halt seen on the last allowed cycle still beats the timeout.
        if (!tmr_enable_i)     w_state_next = c_ST_RELEASE;
        else if (w_all_halted) w_state_next = c_ST_RESYNC;
        else if (w_tmo_hit)    w_state_next = c_ST_FATAL;
      end
      c_ST_RESYNC: begin
        // The resync routine has no bound here; software owns its duration.
        if (!tmr_enable_i || resync_done_i) w_state_next = c_ST_RELEASE;
      end
      c_ST_RELEASE: begin
        if (w_none_halted)  w_state_next = r_drop_pending ? c_ST_DISABLED : c_ST_ACTIVE;
        else if (w_tmo_hit) w_state_next = c_ST_FATAL;
      end
      c_ST_FATAL: begin
        if (!tmr_enable_i) w_state_next = c_ST_DISABLED;
      end
      default: w_state_next = c_ST_DISABLED;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore: a pure function of registered state)
  // ---------------------------------------------------------------------------
  always_comb begin
    voter_enable_o  = 1'b0;
    debug_req_o     = '0;
    recovery_busy_o = 1'b0;
    fatal_o         = 1'b0;
    case (r_state)
      c_ST_ACTIVE: begin
        voter_enable_o = 1'b1;
      end
      c_ST_HALT, c_ST_RESYNC: begin
        debug_req_o     = '1;
        recovery_busy_o = 1'b1;
      end
      c_ST_RELEASE: begin
        recovery_busy_o = 1'b1;
      end
      c_ST_FATAL: begin
        fatal_o = 1'b1;
      end
      default: begin
        voter_enable_o = 1'b0;
      end
    endcase
  end

  assign resync_start_o = r_resync_pulse;
  assign faulty_hart_o  = r_faulty_hart;
  assign fault_count_o  = r_fault_cnt;

  // ---------------------------------------------------------------------------
  // Timeout counter: restarts on every state change so it measures time spent
  // in the current HALT or RELEASE visit only.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == c_ST_HALT) || (r_state == c_ST_RELEASE)) begin
      r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // drop_pending remembers an abort so RELEASE exits to DISABLED, not ACTIVE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drop_pending <= 1'b0;
    end else if (w_state_next == c_ST_DISABLED) begin
      r_drop_pending <= 1'b0;
    end else if (((r_state == c_ST_HALT) || (r_state == c_ST_RESYNC)) && !tmr_enable_i) begin
      r_drop_pending <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Resync start: high only in the first RESYNC cycle, which can only be
  // reached from HALT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resync_pulse <= 1'b0;
    end else begin
      r_resync_pulse <= (r_state == c_ST_HALT) && (w_state_next == c_ST_RESYNC);
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky fault record; survives DISABLED and FATAL, cleared only by reset.
  // ---------------------------------------------------------------------------
  assign w_capture_fault = (r_state == c_ST_ACTIVE) && (w_state_next == c_ST_HALT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_faulty_hart <= '0;
      r_fault_cnt   <= '0;
    end else if (w_capture_fault) begin
      r_faulty_hart <= voter_error_id_i;
      if (r_fault_cnt != '1) begin
        r_fault_cnt <= r_fault_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tmr_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmr_recovery_ctrl
// Purpose  : Self-checking bench for tmr_recovery_ctrl. Scenario tasks drive
//            randomized recovery sequences; expected outputs come from the
//            externally visible behaviour of each recovery phase and a
//            fault-record model (last hart, saturating count).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_recovery_ctrl;

  localparam int NH      = 3;
  localparam int TMO     = 8;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          err;
  logic [NH-1:0] id;
  logic [NH-1:0] halted;
  logic          done;

  logic          voter_enable_o;
  logic [NH-1:0] debug_req_o;
  logic          resync_start_o;
  logic [NH-1:0] faulty_hart_o;
  logic [CW-1:0] fault_count_o;
  logic          recovery_busy_o;
  logic          fatal_o;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            m_cnt;
  logic [NH-1:0] m_faulty;

  tmr_recovery_ctrl #(
    .NHARTS  (NH),
    .TIMEOUT (TMO),
    .CNT_W   (CW)
  ) u_dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .tmr_enable_i     (en),
    .voter_error_i    (err),
    .voter_error_id_i (id),
    .core_halted_i    (halted),
    .resync_done_i    (done),
    .voter_enable_o   (voter_enable_o),
    .debug_req_o      (debug_req_o),
    .resync_start_o   (resync_start_o),
    .faulty_hart_o    (faulty_hart_o),
    .fault_count_o    (fault_count_o),
    .recovery_busy_o  (recovery_busy_o),
    .fatal_o          (fatal_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // Expected {voter_enable, debug_req[2:0], resync_start, busy, fatal} per phase.
  function automatic logic [6:0] mode_out(input string m);
    if (m == "on")       return 7'b1_000_0_0_0;
    if (m == "halt")     return 7'b0_111_0_1_0;
    if (m == "rsfirst")  return 7'b0_111_1_1_0;
    if (m == "resync")   return 7'b0_111_0_1_0;
    if (m == "release")  return 7'b0_000_0_1_0;
    if (m == "fatal")    return 7'b0_000_0_0_1;
    return 7'b0;
  endfunction

  function automatic logic [6:0] obs_out();
    return {voter_enable_o, debug_req_o, resync_start_o, recovery_busy_o, fatal_o};
  endfunction

  function automatic logic [6:0] exp_sticky();
    return {m_faulty, CW'(m_cnt)};
  endfunction

  function automatic logic [6:0] obs_sticky();
    return {faulty_hart_o, fault_count_o};
  endfunction

  function automatic void model_fault(input logic [NH-1:0] oh);
    m_faulty = oh;
    if (m_cnt < CNT_MAX) m_cnt++;
  endfunction

  function automatic logic [NH-1:0] rand_onehot();
    return NH'(1) << $urandom_range(0, NH - 1);
  endfunction

  // Full single-fault recovery from ACTIVE back to ACTIVE.
  // hd/ld: cycles with incomplete halt / incomplete release; rd: extra resync cycles.
  task automatic run_recovery(input int hd, input int rd, input int ld);
    logic [NH-1:0] oh;
    oh  = rand_onehot();
    err = 1'b1; id = oh;
    @(negedge clk);
    err = 1'b0; id = NH'($urandom);
    model_fault(oh);
    n_cmp++; if (obs_out() !== mode_out("halt")) begin n_bad++; $display("FAIL rec_halt: got %b want %b", obs_out(), mode_out("halt")); end
    n_cmp++; if (obs_sticky() !== exp_sticky()) begin n_bad++; $display("FAIL rec_sticky: got %b want %b", obs_sticky(), exp_sticky()); end
    for (int i = 0; i < hd; i++) begin
      halted = NH'($urandom_range(0, 6));
      @(negedge clk);
      n_cmp++; if (obs_out() !== mode_out("halt")) begin n_bad++; $display("FAIL rec_halt_wait: got %b want %b", obs_out(), mode_out("halt")); end
    end
    halted = '1;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("rsfirst")) begin n_bad++; $display("FAIL rec_resync_start: got %b want %b", obs_out(), mode_out("rsfirst")); end
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      n_cmp++; if (obs_out() !== mode_out("resync")) begin n_bad++; $display("FAIL rec_resync: got %b want %b", obs_out(), mode_out("resync")); end
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    n_cmp++; if (obs_out() !== mode_out("release")) begin n_bad++; $display("FAIL rec_release: got %b want %b", obs_out(), mode_out("release")); end
    for (int i = 0; i < ld; i++) begin
      halted = NH'($urandom_range(1, 7));
      @(negedge clk);
      n_cmp++; if (obs_out() !== mode_out("release")) begin n_bad++; $display("FAIL rec_release_wait: got %b want %b", obs_out(), mode_out("release")); end
    end
    halted = '0;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("on")) begin n_bad++; $display("FAIL rec_back_active: got %b want %b", obs_out(), mode_out("on")); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (obs_out() !== 7'b0) begin n_bad++; $display("FAIL reset_outputs: got %b want %b", obs_out(), 7'b0); end
    n_cmp++; if (obs_sticky() !== 7'b0) begin n_bad++; $display("FAIL reset_sticky: got %b want %b", obs_sticky(), 7'b0); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("off")) begin n_bad++; $display("FAIL disabled_idle: got %b want %b", obs_out(), mode_out("off")); end
    en = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("on")) begin n_bad++; $display("FAIL enable: got %b want %b", obs_out(), mode_out("on")); end
  endtask

  task automatic test_single_fault();
    for (int n = 0; n < 6; n++)
      run_recovery($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 6));
  endtask

  task automatic test_fatal_multi();
    logic [NH-1:0] mv;
    do mv = NH'($urandom); while ($countones(mv) < 2);
    err = 1'b1; id = mv;
    @(negedge clk);
    err = 1'b0;
    n_cmp++; if (obs_out() !== mode_out("fatal")) begin n_bad++; $display("FAIL multi_fatal: got %b want %b", obs_out(), mode_out("fatal")); end
    n_cmp++; if (obs_sticky() !== exp_sticky()) begin n_bad++; $display("FAIL multi_sticky: got %b want %b", obs_sticky(), exp_sticky()); end
    repeat ($urandom_range(1, 3)) begin
      err = 1'($urandom); id = NH'($urandom); halted = NH'($urandom);
      @(negedge clk);
      n_cmp++; if (obs_out() !== mode_out("fatal")) begin n_bad++; $display("FAIL fatal_hold: got %b want %b", obs_out(), mode_out("fatal")); end
    end
    err = 1'b0; halted = '0; en = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("off")) begin n_bad++; $display("FAIL fatal_exit: got %b want %b", obs_out(), mode_out("off")); end
    n_cmp++; if (obs_sticky() !== exp_sticky()) begin n_bad++; $display("FAIL fatal_exit_sticky: got %b want %b", obs_sticky(), exp_sticky()); end
    en = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("on")) begin n_bad++; $display("FAIL fatal_reenable: got %b want %b", obs_out(), mode_out("on")); end
  endtask

  task automatic test_zero_id();
    repeat (3) begin
      err = 1'b1; id = '0;
      @(negedge clk);
      n_cmp++; if (obs_out() !== mode_out("on")) begin n_bad++; $display("FAIL zero_id: got %b want %b", obs_out(), mode_out("on")); end
    end
    err = 1'b0;
    n_cmp++; if (obs_sticky() !== exp_sticky()) begin n_bad++; $display("FAIL zero_id_sticky: got %b want %b", obs_sticky(), exp_sticky()); end
  endtask

  task automatic test_enable_priority();
    en = 1'b0; err = 1'b1; id = rand_onehot();
    @(negedge clk);
    err = 1'b0;
    n_cmp++; if (obs_out() !== mode_out("off")) begin n_bad++; $display("FAIL en_priority: got %b want %b", obs_out(), mode_out("off")); end
    n_cmp++; if (obs_sticky() !== exp_sticky()) begin n_bad++; $display("FAIL en_priority_sticky: got %b want %b", obs_sticky(), exp_sticky()); end
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_halt_timeout();
    logic [NH-1:0] oh;
    // Full halt seen on the very last allowed HALT/RELEASE cycle still recovers.
    run_recovery(TMO - 1, 1, TMO - 1);
    oh = rand_onehot();
    err = 1'b1; id = oh;
    @(negedge clk);
    err = 1'b0;
    model_fault(oh);
    n_cmp++; if (obs_out() !== mode_out("halt")) begin n_bad++; $display("FAIL tmo_halt_entry: got %b want %b", obs_out(), mode_out("halt")); end
    for (int k = 2; k <= TMO; k++) begin
      halted = NH'($urandom_range(0, 6));
      @(negedge clk);
      n_cmp++; if (obs_out() !== mode_out("halt")) begin n_bad++; $display("FAIL tmo_halt_wait: got %b want %b", obs_out(), mode_out("halt")); end
    end
    halted = NH'($urandom_range(0, 6));
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("fatal")) begin n_bad++; $display("FAIL tmo_halt_fatal: got %b want %b", obs_out(), mode_out("fatal")); end
    n_cmp++; if (obs_sticky() !== exp_sticky()) begin n_bad++; $display("FAIL tmo_halt_sticky: got %b want %b", obs_sticky(), exp_sticky()); end
    en = 1'b0; halted = '0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("on")) begin n_bad++; $display("FAIL tmo_halt_recover: got %b want %b", obs_out(), mode_out("on")); end
  endtask

  task automatic test_release_timeout();
    logic [NH-1:0] oh;
    oh = rand_onehot();
    err = 1'b1; id = oh;
    @(negedge clk);
    err = 1'b0;
    model_fault(oh);
    halted = '1;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("rsfirst")) begin n_bad++; $display("FAIL tmo_rel_resync: got %b want %b", obs_out(), mode_out("rsfirst")); end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    n_cmp++; if (obs_out() !== mode_out("release")) begin n_bad++; $display("FAIL tmo_rel_entry: got %b want %b", obs_out(), mode_out("release")); end
    for (int k = 2; k <= TMO; k++) begin
      halted = NH'($urandom_range(1, 7));
      @(negedge clk);
      n_cmp++; if (obs_out() !== mode_out("release")) begin n_bad++; $display("FAIL tmo_rel_wait: got %b want %b", obs_out(), mode_out("release")); end
    end
    halted = NH'($urandom_range(1, 7));
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("fatal")) begin n_bad++; $display("FAIL tmo_rel_fatal: got %b want %b", obs_out(), mode_out("fatal")); end
    en = 1'b0; halted = '0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_drop_in_resync();
    logic [NH-1:0] oh;
    oh = rand_onehot();
    err = 1'b1; id = oh;
    @(negedge clk);
    err = 1'b0;
    model_fault(oh);
    halted = '1;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("rsfirst")) begin n_bad++; $display("FAIL drop_rs_start: got %b want %b", obs_out(), mode_out("rsfirst")); end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("release")) begin n_bad++; $display("FAIL drop_rs_release: got %b want %b", obs_out(), mode_out("release")); end
    repeat ($urandom_range(0, 3)) begin
      halted = NH'($urandom_range(1, 7));
      @(negedge clk);
      n_cmp++; if (obs_out() !== mode_out("release")) begin n_bad++; $display("FAIL drop_rs_wait: got %b want %b", obs_out(), mode_out("release")); end
    end
    halted = '0;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("off")) begin n_bad++; $display("FAIL drop_rs_disabled: got %b want %b", obs_out(), mode_out("off")); end
    en = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("on")) begin n_bad++; $display("FAIL drop_rs_reenable: got %b want %b", obs_out(), mode_out("on")); end
  endtask

  task automatic test_drop_in_halt();
    logic [NH-1:0] oh;
    oh = rand_onehot();
    err = 1'b1; id = oh;
    @(negedge clk);
    err = 1'b0;
    model_fault(oh);
    halted = NH'($urandom_range(0, 6));
    en = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("release")) begin n_bad++; $display("FAIL drop_halt_release: got %b want %b", obs_out(), mode_out("release")); end
    halted = '0;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("off")) begin n_bad++; $display("FAIL drop_halt_disabled: got %b want %b", obs_out(), mode_out("off")); end
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) run_recovery(0, 0, 0);
  endtask

  task automatic test_saturation();
    for (int n = 0; n < CNT_MAX + 3; n++)
      run_recovery($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    n_cmp++; if (fault_count_o !== CW'(CNT_MAX)) begin n_bad++; $display("FAIL saturate: got %h want %h", fault_count_o, CW'(CNT_MAX)); end
  endtask

  task automatic test_async_reset();
    logic [NH-1:0] oh;
    oh = rand_onehot();
    err = 1'b1; id = oh;
    @(negedge clk);
    err = 1'b0;
    model_fault(oh);
    n_cmp++; if (obs_out() !== mode_out("halt")) begin n_bad++; $display("FAIL areset_halt: got %b want %b", obs_out(), mode_out("halt")); end
    #2 rst_n = 1'b0;
    #1;
    m_cnt = 0; m_faulty = '0;
    n_cmp++; if (obs_out() !== 7'b0) begin n_bad++; $display("FAIL areset_outputs: got %b want %b", obs_out(), 7'b0); end
    n_cmp++; if (obs_sticky() !== exp_sticky()) begin n_bad++; $display("FAIL areset_sticky: got %b want %b", obs_sticky(), exp_sticky()); end
    halted = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs_out() !== mode_out("on")) begin n_bad++; $display("FAIL areset_restart: got %b want %b", obs_out(), mode_out("on")); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; err = 1'b0; id = '0; halted = '0; done = 1'b0;
    m_cnt = 0; m_faulty = '0;
    test_reset();
    test_single_fault();
    test_fatal_multi();
    test_zero_id();
    test_enable_priority();
    test_halt_timeout();
    test_release_timeout();
    test_drop_in_resync();
    test_drop_in_halt();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
